regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file for the five-stage pipeline, successor to the single-configuration integer register file. It adds configurable width, depth and read-port count, a write-to-read bypass, a per-register pending-write scoreboard, and a sequential clear engine so that the storage array needs no reset fan-out. It sits in the decode stage: decode reads operands and scoreboard state; writeback writes results.

## Interface
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register address width; NUM_REGS = 2**ADDR_WIDTH.
- NUM_RPORTS, 2: number of combinational read ports, 1..4.
- ZERO_REG, 1: when 1, register 0 is hardwired to zero and never marked busy.

- sys_clk  in  1  clock; all state changes on the rising edge.
- sys_rst  in  1  reset; asynchronous, active-high.
- raddr  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- rdata  out  NUM_RPORTS*DATA_WIDTH  read data, packed the same way.
- rbusy  out  NUM_RPORTS  scoreboard bit of each read address.
- wen  in  1  write enable (writeback).
- waddr  in  ADDR_WIDTH  write address.
- wdata  in  DATA_WIDTH  write data.
- sb_set  in  1  mark sb_addr pending (an instruction writing sb_addr has issued).
- sb_addr  in  ADDR_WIDTH  register to mark pending.
- ready  out  1  1 when the clear sequence is done and the file accepts traffic.

## Operation
- States: INIT, RUN. Reset forces INIT, clear index = 0, all scoreboard bits = 0.
- INIT: each cycle writes 0 to entry[index] and increments index; on the cycle index == NUM_REGS-1, the state moves to RUN. wen and sb_set are ignored. rdata = 0 and rbusy = 0 on all ports.
- RUN: wen=1 writes wdata to entry[waddr] at the edge, except waddr==0 with ZERO_REG=1, which is dropped.
- Bypass: in RUN, if wen=1 and raddr[p]==waddr (and the write is not dropped), rdata[p] = wdata in the same cycle; otherwise rdata[p] = entry[raddr[p]]. Reads of register 0 with ZERO_REG=1 return 0.
- Scoreboard: an accepted write clears busy[waddr]; sb_set sets busy[sb_addr]. If both hit the same address in the same cycle, set wins. sb_set to 0 with ZERO_REG=1 is ignored.
- rbusy[p] = busy[raddr[p]] as registered. It is not bypassed: a write clearing the bit this cycle still shows busy=1 until the edge. Decode combines it with the data bypass.
- Reset mid-operation: ready drops to 0 asynchronously, and the file re-enters INIT and fully re-clears. Array contents are undefined until the clear completes.

## Timing
- Read path is combinational: zero latency, including the bypass.
- Write and scoreboard updates become visible one cycle after the edge.
- ready: 0 during reset. After sys_rst deasserts, ready rises on the edge NUM_REGS cycles later (32 for the defaults).
- Reset values: ready=0, rdata=0, rbusy=0.
- Any number of read ports may address the same register, with no conflicts.

## Structure
- Shared package regfile_pkg:
  - state enum (INIT, RUN);
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - a function that extracts port p from a packed bus.
- One sub-module, rf_scoreboard: NUM_REGS busy bits with the set/clear priority rule and read muxes. The top level holds the array, the clear FSM and the bypass.
- Only the FSM and scoreboard use sys_rst. The array is written solely by the clear engine and writeback.

## Test plan
- Reset clear: preload garbage, pulse sys_rst → ready=0 for exactly 32 cycles after deassert, then 1; every raddr reads 0.
- Write/read: in RUN, wen=1, waddr=5, wdata=0xDEADBEEF with raddr0=5 → rdata0=0xDEADBEEF in the same cycle (bypass) and on the next cycle (stored).
- Register 0 (ZERO_REG=1): wen=1, waddr=0, wdata=0x1234 and sb_set with sb_addr=0 → rdata=0 and rbusy=0 on every subsequent cycle.
- Scoreboard priority:
  - sb_set on r7 → rbusy=1 next cycle.
  - Then write r7 together with sb_set on r7 in the same cycle → rbusy stays 1.
  - Then a lone write to r7 → rbusy=0 next cycle.
- Reset mid-run: assert sys_rst while r3=0x55 is busy → ready=0 immediately and rbusy=0. After the clear completes, r3 reads 0.
- INIT ignores traffic: drive wen to r9=0xFF during INIT → after ready=1, r9 reads 0 and is not busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   typedef enum logic {StInit, StRun} rf_state_e;

   localparam int unsigned DefDataWidth  = 32;
   localparam int unsigned DefAddrWidth  = 5;
   localparam int unsigned MaxBusWidth   = 256;
   localparam int unsigned MaxFieldWidth = 64;

   // Extract field p (each w bits wide) from a packed bus zero-extended to MaxBusWidth.
   function automatic logic [MaxFieldWidth-1:0] port_field(input logic [MaxBusWidth-1:0] bus,
                                                           input int unsigned p,
                                                           input int unsigned w);
      logic [MaxBusWidth-1:0] mask;
      mask = ~({MaxBusWidth{1'b1}} << w);
      return MaxFieldWidth'((bus >> (p * w)) & mask);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set beats clear, registered read muxes.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned NUM_RPORTS = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst,
   input  logic                           enable,
   input  logic                           clr_en,
   input  logic [ADDR_WIDTH-1:0]          clr_addr,
   input  logic                           set_en,
   input  logic [ADDR_WIDTH-1:0]          set_addr,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RPORTS-1:0]          rbusy
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

   logic [NumRegs-1:0]     busy_q, busy_d;
   logic [MaxBusWidth-1:0] raddr_ext;
   logic                   set_ok;

   assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

   always_comb begin
      busy_d = busy_q;
      if (enable) begin
         if (clr_en) busy_d[clr_addr] = 1'b0;
         // Applied after the clear so a same-cycle set wins.
         if (set_ok) busy_d[set_addr] = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign raddr_ext = MaxBusWidth'(raddr);

   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      assign ra       = ADDR_WIDTH'(port_field(raddr_ext, int'(p), ADDR_WIDTH));
      assign rbusy[p] = enable & busy_q[ra];
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, pending-write scoreboard and a
// sequential clear engine so the storage array itself carries no reset.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned NUM_RPORTS = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
   output logic [NUM_RPORTS-1:0]            rbusy,
   input  logic                             wen,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH-1:0]            wdata,
   input  logic                             sb_set,
   input  logic [ADDR_WIDTH-1:0]            sb_addr,
   output logic                             ready
);

   localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

   rf_state_e              state_q;
   logic [ADDR_WIDTH-1:0]  idx_q;
   logic                   ready_q;
   logic                   wr_accept;
   logic [DATA_WIDTH-1:0]  mem [NumRegs];
   logic [MaxBusWidth-1:0] raddr_ext;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= StInit;
         idx_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            StInit: begin
               idx_q <= idx_q + 1'b1;
               if (idx_q == ADDR_WIDTH'(NumRegs - 1)) begin
                  state_q <= StRun;
                  ready_q <= 1'b1;
               end
            end
            StRun: begin
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= StInit;
               idx_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign wr_accept = ready_q && wen && !((ZERO_REG != 0) && (waddr == '0));

   // No reset on the array: the clear engine owns the write port until ready.
   always_ff @(posedge sys_clk) begin
      if (!ready_q) begin
         mem[idx_q] <= '0;
      end else if (wr_accept) begin
         mem[waddr] <= wdata;
      end
   end

   assign raddr_ext = MaxBusWidth'(raddr);

   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rport
      logic [ADDR_WIDTH-1:0] ra;
      logic                  rd_zero;
      logic                  rd_bypass;
      assign ra        = ADDR_WIDTH'(port_field(raddr_ext, int'(p), ADDR_WIDTH));
      assign rd_zero   = (ZERO_REG != 0) && (ra == '0);
      assign rd_bypass = wr_accept && (ra == waddr);
      assign rdata[p*DATA_WIDTH +: DATA_WIDTH] =
         (!ready_q || rd_zero) ? '0 : (rd_bypass ? wdata : mem[ra]);
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_RPORTS (NUM_RPORTS),
      .ZERO_REG   (ZERO_REG)
   ) u_scoreboard (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .enable   (ready_q),
      .clr_en   (wr_accept),
      .clr_addr (waddr),
      .set_en   (sb_set),
      .set_addr (sb_addr),
      .raddr    (raddr),
      .rbusy    (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, reset sequences, random vs model.
module tb_regfile_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NP = 2;
   localparam int NR = 32;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic [NP*AW-1:0] raddr;
   logic [NP*DW-1:0] rdata;
   logic [NP-1:0]    rbusy;
   logic             wen;
   logic [AW-1:0]    waddr;
   logic [DW-1:0]    wdata;
   logic             sb_set;
   logic [AW-1:0]    sb_addr;
   logic             ready;

   int tests = 0;
   int fails = 0;

   logic [DW-1:0] m_mem [NR];
   bit            m_busy [NR];

   typedef struct {
      logic          wen;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          sb_set;
      logic [AW-1:0] sb_addr;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic [DW-1:0] exp0;
      logic [DW-1:0] exp1;
      logic [1:0]    expb;
   } vec_t;

   vec_t vecs [12];

   regfile_mp #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .NUM_RPORTS (NP),
      .ZERO_REG   (1)
   ) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .raddr   (raddr),
      .rdata   (rdata),
      .rbusy   (rbusy),
      .wen     (wen),
      .waddr   (waddr),
      .wdata   (wdata),
      .sb_set  (sb_set),
      .sb_addr (sb_addr),
      .ready   (ready)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      wen = 1'b0; waddr = '0; wdata = '0; sb_set = 1'b0; sb_addr = '0;
   endtask

   task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_mem[i]  = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Releases reset at a negedge and counts edges until ready rises.
   task automatic release_and_wait(input string name);
      int cnt;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      cnt = 0;
      while (ready !== 1'b1 && cnt < 100) begin
         @(posedge sys_clk);
         #1;
         cnt++;
      end
      check(name, 64'(cnt), 64'(NR));
      set_idle();
      model_reset();
   endtask

   function automatic logic [AW-1:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
      return AW'($urandom_range(0, 7));
   endfunction

   initial begin
      logic [AW-1:0] ra [NP];
      logic [DW-1:0] ed;
      set_idle();
      set_raddr(5'd3, 5'd9);

      // Reset values
      #3;
      check("reset_ready", 64'(ready), 64'(0));
      check("reset_rbusy", 64'(rbusy), 64'(0));
      check("reset_rdata", 64'(rdata), 64'(0));
      repeat (2) @(posedge sys_clk);
      release_and_wait("ready_latency_first");

      // Fill with garbage, then reset mid-run with traffic driven during INIT
      for (int i = 0; i < NR; i++) begin
         @(negedge sys_clk);
         wen = 1'b1; waddr = AW'(i); wdata = $urandom;
         sb_set = 1'b1; sb_addr = AW'(NR - 1 - i);
      end
      @(negedge sys_clk);
      set_idle();
      sys_rst = 1'b1;
      #1;
      check("garbage_reset_ready", 64'(ready), 64'(0));
      @(negedge sys_clk);
      wen = 1'b1; waddr = 5'd9; wdata = 32'hFF; sb_set = 1'b1; sb_addr = 5'd9;
      set_raddr(5'd9, 5'd9);
      @(posedge sys_clk);
      release_and_wait("ready_latency_clear");
      for (int a = 0; a < NR; a++) begin
         set_raddr(AW'(a), AW'(NR - 1 - a));
         #1;
         check($sformatf("clear_rdata_r%0d", a), 64'(rdata), 64'(0));
         check($sformatf("clear_rbusy_r%0d", a), 64'(rbusy), 64'(0));
      end
      @(negedge sys_clk);
      set_raddr(5'd9, 5'd9);
      #2;
      check("init_ignored_r9_data", 64'(rdata), 64'(0));
      check("init_ignored_r9_busy", 64'(rbusy), 64'(0));

      // Directed vector table, applied from a fully cleared, idle file
      vecs[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        2'b00};
      vecs[2]  = '{1'b1, 5'd0, 32'h1234,     1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
      vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd7, 32'h0,        32'h0,        2'b00};
      vecs[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 2'b01};
      vecs[6]  = '{1'b1, 5'd7, 32'hA5A5,     1'b1, 5'd7, 5'd7, 5'd7, 32'hA5A5,     32'hA5A5,     2'b11};
      vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5,     32'hA5A5,     2'b11};
      vecs[8]  = '{1'b1, 5'd7, 32'h77,       1'b0, 5'd0, 5'd7, 5'd7, 32'h77,       32'h77,       2'b11};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h77,       32'h77,       2'b00};
      vecs[10] = '{1'b1, 5'd3, 32'h55,       1'b1, 5'd3, 5'd3, 5'd7, 32'h55,       32'h77,       2'b00};
      vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h55,       32'h55,       2'b11};
      for (int i = 0; i < 12; i++) begin
         @(negedge sys_clk);
         wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
         sb_set = vecs[i].sb_set; sb_addr = vecs[i].sb_addr;
         set_raddr(vecs[i].ra0, vecs[i].ra1);
         #2;
         check($sformatf("vec%0d_rdata0", i), 64'(rdata[DW-1:0]), 64'(vecs[i].exp0));
         check($sformatf("vec%0d_rdata1", i), 64'(rdata[2*DW-1:DW]), 64'(vecs[i].exp1));
         check($sformatf("vec%0d_rbusy", i), 64'(rbusy), 64'(vecs[i].expb));
      end

      // Reset while r3 holds 0x55 and is busy
      @(negedge sys_clk);
      set_idle();
      set_raddr(5'd3, 5'd3);
      #2;
      sys_rst = 1'b1;
      #1;
      check("midrun_reset_ready", 64'(ready), 64'(0));
      check("midrun_reset_rbusy", 64'(rbusy), 64'(0));
      check("midrun_reset_rdata", 64'(rdata), 64'(0));
      @(posedge sys_clk);
      release_and_wait("ready_latency_midrun");
      #1;
      check("midrun_r3_cleared", 64'(rdata), 64'(0));
      check("midrun_r3_not_busy", 64'(rbusy), 64'(0));

      // Random traffic against the reference model
      for (int n = 0; n < 400; n++) begin
         @(negedge sys_clk);
         wen = ($urandom_range(0, 1) == 1); waddr = rnd_addr(); wdata = $urandom;
         sb_set = ($urandom_range(0, 2) == 0); sb_addr = rnd_addr();
         ra[0] = rnd_addr();
         ra[1] = ($urandom_range(0, 3) == 0) ? waddr : rnd_addr();
         set_raddr(ra[0], ra[1]);
         #2;
         for (int p = 0; p < NP; p++) begin
            if (ra[p] == 0) ed = '0;
            else if (wen && ra[p] == waddr) ed = wdata;
            else ed = m_mem[ra[p]];
            check($sformatf("rand%0d_rdata%0d", n, p), 64'(rdata[p*DW +: DW]), 64'(ed));
            check($sformatf("rand%0d_rbusy%0d", n, p), 64'(rbusy[p]), 64'(m_busy[ra[p]]));
         end
         @(posedge sys_clk);
         if (wen && waddr != 0) begin
            m_mem[waddr]  = wdata;
            m_busy[waddr] = 1'b0;
         end
         if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
      end

      @(negedge sys_clk);
      set_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
